// File: rtl/cfg_frame_loader_pkg.sv
// Shared definitions for the configuration frame loader: frame bit layout,
// FSM states and default geometry.
package cfg_frame_loader_pkg;

    localparam int DEF_NUM_WORDS = 13;
    localparam int DEF_FRAME_W   = 39;
    localparam int FRAME_BITS    = 39;

    localparam int DATA_LSB = 7;
    localparam int CSB_BIT  = 6;
    localparam int OEB_BIT  = 5;
    localparam int WEB_BIT  = 4;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_W,
        HOLD_W,
        SHIFT_R,
        HOLD_R,
        FIN
    } state_e;

    // Output enable is never asserted and web stays low; csb selects write (0) or commit (1).
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [ADDR_W-1:0] addr,
                                                          input logic [DATA_W-1:0] data,
                                                          input logic              csb);
        logic [FRAME_BITS-1:0] f;
        f                          = '0;
        f[FRAME_BITS-1:DATA_LSB]   = data;
        f[CSB_BIT]                 = csb;
        f[OEB_BIT]                 = 1'b1;
        f[WEB_BIT]                 = 1'b0;
        f[ADDR_W-1:0]              = addr;
        return f;
    endfunction

endpackage

// File: rtl/cfg_frame_shifter.sv
// Parallel-load, MSB-first shift register feeding the tile scan chain.
module cfg_frame_shifter #(
    parameter int W = 39
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         shift_i,
    output logic         msb_o
);

    logic [W-1:0] sr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= load_val_i;
        end else if (shift_i) begin
            sr_q <= {sr_q[W-2:0], 1'b0};
        end
    end

    assign msb_o = sr_q[W-1];

endmodule

// File: rtl/cfg_frame_loader.sv
// Serialises host config words into a write frame followed by a commit frame
// on the tile scan chain, with hold gaps, completion pulse and load counter.
module cfg_frame_loader
    import cfg_frame_loader_pkg::*;
#(
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int FRAME_W   = DEF_FRAME_W,
    parameter int HOLD_CYC  = 2
) (
    input  logic        cfg_clk,
    input  logic        cfg_rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic        err_clr,
    output logic [4:0]  words_loaded,
    output logic        cfg_scan_en,
    output logic        cfg_scan_in,
    output logic        cfg_lut_we
);

    localparam int                CNT_W     = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_W - 1);
    localparam logic [2:0]        LAST_HOLD = 3'(HOLD_CYC - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [2:0]         hold_cnt_q;
    logic [3:0]         addr_q;
    logic               scan_en_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [4:0]         count_q;

    logic               hs;
    logic               addr_ok;
    logic               sh_load;
    logic [FRAME_W-1:0] sh_val;
    logic               sh_msb;

    assign hs      = wr_valid & (state_q == IDLE);
    assign addr_ok = {28'd0, wr_addr} < 32'(NUM_WORDS);

    // The write frame is captured at handshake so later host changes cannot leak in;
    // the commit frame is loaded on the last hold cycle, just before it shifts.
    assign sh_load = (hs & addr_ok) | ((state_q == HOLD_W) && (hold_cnt_q == LAST_HOLD));
    assign sh_val  = (state_q == IDLE) ? FRAME_W'(build_frame(wr_addr, wr_data, 1'b0))
                                       : FRAME_W'(build_frame(addr_q, 32'd0, 1'b1));

    cfg_frame_shifter #(.W(FRAME_W)) u_shifter (
        .clk        (cfg_clk),
        .rst        (cfg_rst),
        .load_i     (sh_load),
        .load_val_i (sh_val),
        .shift_i    (scan_en_q),
        .msb_o      (sh_msb)
    );

    always_ff @(posedge cfg_clk or posedge cfg_rst) begin
        if (cfg_rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            hold_cnt_q <= '0;
            addr_q     <= '0;
            scan_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hs && addr_ok) begin
                        addr_q    <= wr_addr;
                        state_q   <= SHIFT_W;
                        scan_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                SHIFT_W, SHIFT_R: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_q   <= (state_q == SHIFT_W) ? HOLD_W : HOLD_R;
                        scan_en_q <= 1'b0;
                        bit_cnt_q <= '0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                HOLD_W, HOLD_R: begin
                    if (hold_cnt_q == LAST_HOLD) begin
                        hold_cnt_q <= '0;
                        if (state_q == HOLD_W) begin
                            state_q   <= SHIFT_R;
                            scan_en_q <= 1'b1;
                        end else begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    scan_en_q <= 1'b0;
                end
            endcase
        end
    end

    // A bad address seen together with err_clr must still leave err set.
    always_ff @(posedge cfg_clk or posedge cfg_rst) begin
        if (cfg_rst) begin
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            if (hs && !addr_ok) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
            if (err_clr) begin
                count_q <= '0;
            end else if ((state_q == FIN) && (count_q != 5'd31)) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign wr_ready     = (state_q == IDLE);
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = count_q;
    assign cfg_scan_en  = scan_en_q;
    assign cfg_scan_in  = scan_en_q & sh_msb;
    assign cfg_lut_we   = 1'b0;

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Randomised self-checking bench: a scan-chain monitor rebuilds frames and a
// tile memory, and the results are compared against a frame-level model.
module tb_cfg_frame_loader;

    localparam int NUM_WORDS = 13;
    localparam int FRAME_W   = 39;
    localparam int HOLD_CYC  = 2;
    localparam int LAT       = 2 * (FRAME_W + HOLD_CYC) + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        busy, done, err;
    logic        err_clr = 1'b0;
    logic [4:0]  words_loaded;
    logic        scan_en, scan_in, lut_we;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] bits;
        int          len;
        int          start;
    } frame_t;

    frame_t      frames_q[$];
    int          done_q[$];
    int          hs_q[$];
    int          cyc = 0;
    logic [63:0] cur_bits = '0;
    int          cur_len = 0;
    int          cur_start = 0;
    bit          in_frame = 0;
    int          idle_bad = 0;
    frame_t      ft;
    logic [38:0] f;
    logic [31:0] tile_mem [16];
    logic [31:0] sent [13];

    int model_cnt = 0;
    bit model_err = 0;

    cfg_frame_loader #(
        .NUM_WORDS (NUM_WORDS),
        .FRAME_W   (FRAME_W),
        .HOLD_CYC  (HOLD_CYC)
    ) dut (
        .cfg_clk      (clk),
        .cfg_rst      (rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_clr      (err_clr),
        .words_loaded (words_loaded),
        .cfg_scan_en  (scan_en),
        .cfg_scan_in  (scan_in),
        .cfg_lut_we   (lut_we)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scan-chain monitor and tile model, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            in_frame = 0;
            cur_len  = 0;
        end else begin
            if (wr_valid && wr_ready) hs_q.push_back(cyc);
            if (scan_en) begin
                if (!in_frame) begin
                    in_frame  = 1;
                    cur_bits  = '0;
                    cur_len   = 0;
                    cur_start = cyc;
                end
                cur_bits = {cur_bits[62:0], scan_in};
                cur_len++;
            end else begin
                if (scan_in) idle_bad++;
                if (in_frame) begin
                    in_frame  = 0;
                    ft.bits   = cur_bits;
                    ft.len    = cur_len;
                    ft.start  = cur_start;
                    frames_q.push_back(ft);
                    f = cur_bits[38:0];
                    if (cur_len == FRAME_W && !f[6] && !f[4]) tile_mem[f[3:0]] = f[38:7];
                end
            end
            if (done) done_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_frame(input logic [3:0] a, input logic [31:0] d, input bit write);
        return {25'd0, (write ? d : 32'd0), ~write, 1'b1, 1'b0, a};
    endfunction

    task automatic run_word(input logic [3:0] a, input logic [31:0] d);
        bit good;
        good = (a < NUM_WORDS);
        frames_q.delete();
        done_q.delete();
        hs_q.delete();
        idle_bad = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        wr_addr  = 4'($urandom);
        wr_data  = $urandom;
        repeat (LAT + 4) @(posedge clk);
        #1;
        if (good) begin
            model_cnt = (model_cnt < 31) ? model_cnt + 1 : 31;
            chk("n_frames", frames_q.size(), 2);
            if (frames_q.size() == 2) begin
                chk("wr_frame", frames_q[0].bits, exp_frame(a, d, 1));
                chk("wr_len", frames_q[0].len, FRAME_W);
                chk("rd_frame", frames_q[1].bits, exp_frame(a, d, 0));
                chk("rd_len", frames_q[1].len, FRAME_W);
                chk("hold_gap", frames_q[1].start - (frames_q[0].start + frames_q[0].len), HOLD_CYC);
            end
            chk("n_done", done_q.size(), 1);
            if (done_q.size() == 1 && hs_q.size() == 1) chk("latency", done_q[0] - hs_q[0], LAT);
        end else begin
            model_err = 1;
            chk("bad_frames", frames_q.size(), 0);
            chk("bad_done", done_q.size(), 0);
        end
        chk("hs_count", hs_q.size(), 1);
        chk("idle_scan_in", idle_bad, 0);
        chk("err", err, model_err);
        chk("words_loaded", words_loaded, model_cnt);
        chk("busy_idle", busy, 0);
        chk("ready_idle", wr_ready, 1);
        $display("word addr=%0d data=0x%08h good=%0d cnt=%0d err=%0d", a, d, good, words_loaded, err);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr   = 1'b0;
        model_err = 0;
        model_cnt = 0;
    endtask

    initial begin
        int  idx;
        bit  acc;
        bit  seen;
        int  spacing_bad;

        #3;
        chk("rst_scan_en", scan_en, 0);
        chk("rst_scan_in", scan_in, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_words", words_loaded, 0);
        chk("lut_we", lut_we, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", wr_ready, 1);

        run_word(4'd1, 32'hDEADBEEF);
        run_word(4'd13, $urandom);
        pulse_err_clr();
        chk("err_cleared", err, 0);
        chk("cnt_cleared", words_loaded, 0);

        wr_valid = 1'b1;
        wr_addr  = 4'd15;
        err_clr  = 1'b1;
        @(posedge clk); #1;
        wr_valid  = 1'b0;
        err_clr   = 1'b0;
        model_err = 1;
        chk("err_clr_vs_bad", err, 1);
        pulse_err_clr();

        for (int i = 0; i < 12; i++) run_word(4'($urandom_range(0, 15)), $urandom);

        pulse_err_clr();
        frames_q.delete();
        done_q.delete();
        hs_q.delete();
        for (int i = 0; i < 13; i++) sent[i] = $urandom;
        idx      = 0;
        wr_valid = 1'b1;
        wr_addr  = 4'd0;
        wr_data  = sent[0];
        for (int c = 0; c < 13 * (LAT + 1) + 20 && idx < 13; c++) begin
            @(negedge clk);
            acc = wr_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 13) begin
                    wr_addr = 4'(idx);
                    wr_data = sent[idx];
                end else begin
                    wr_valid = 1'b0;
                end
            end
        end
        wr_valid = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;
        model_cnt = 13;
        chk("stream_hs", idx, 13);
        chk("stream_done", done_q.size(), 13);
        chk("stream_frames", frames_q.size(), 26);
        spacing_bad = 0;
        for (int i = 1; i < done_q.size(); i++)
            if (done_q[i] - done_q[i-1] != LAT + 1) spacing_bad++;
        chk("done_spacing", spacing_bad, 0);
        chk("stream_words", words_loaded, model_cnt);
        for (int i = 0; i < 13; i++) chk("tile_word", tile_mem[i], sent[i]);
        $display("stream done=%0d words=%0d", done_q.size(), words_loaded);

        done_q.delete();
        wr_valid = 1'b1;
        wr_addr  = 4'd5;
        wr_data  = $urandom;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge clk);
            if (in_frame && cur_len == 20) seen = 1;
        end
        chk("reached_bit20", seen, 1);
        #2 rst = 1'b1;
        #1;
        model_cnt = 0;
        model_err = 0;
        chk("abort_scan_en", scan_en, 0);
        chk("abort_scan_in", scan_in, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_words", words_loaded, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        chk("no_done_after_abort", done_q.size(), 0);
        $display("abort mid-shift: done seen=%0d", done_q.size());
        run_word(4'd5, $urandom);

        done_q.delete();
        wr_valid = 1'b1;
        wr_addr  = 4'd3;
        wr_data  = $urandom;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < LAT + 10 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("fin_reached", seen, 1);
        chk("cnt_before_clr", words_loaded, model_cnt);
        pulse_err_clr();
        chk("cnt_clr_in_fin", words_loaded, 0);
        chk("done_pulsed", done_q.size(), 1);
        $display("err_clr in FIN: words=%0d done_pulses=%0d", words_loaded, done_q.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cfg_frame_loader.md
CFG_FRAME_LOADER -- requirements
Module: cfg_frame_loader

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 13; number of valid configuration word addresses (0..NUM_WORDS-1).
REQ-002 SHALL have parameter FRAME_W, default 39; scan-frame length in bits.
REQ-003 SHALL have parameter HOLD_CYC, default 2; idle cycles after each completed frame shift (range 1..7).
REQ-004 SHALL have port cfg_clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port cfg_rst  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have port wr_valid  in  1  host word request.
REQ-007 SHALL have port wr_ready  out  1  loader accepts a word.
REQ-008 SHALL have port wr_addr  in  4  target config word address.
REQ-009 SHALL have port wr_data  in  32  config word payload.
REQ-010 SHALL have port busy  out  1  a word is in flight.
REQ-011 SHALL have port done  out  1  one-cycle pulse when a word completes.
REQ-012 SHALL have port err  out  1  sticky bad-address flag.
REQ-013 SHALL have port err_clr  in  1  clears err and words_loaded.
REQ-014 SHALL have port words_loaded  out  5  count of successfully loaded words.
REQ-015 SHALL have port cfg_scan_en  out  1  tile scan-chain shift enable.
REQ-016 SHALL have port cfg_scan_in  out  1  tile scan-chain serial data.
REQ-017 SHALL have port cfg_lut_we  out  1  tile LUT write enable; driven constant 0.

Function
REQ-018 Frame format SHALL be: [38:7] = data, [6] = csb, [5] = oeb (always 1), [4] = web (always 0), [3:0] = addr.
REQ-019 Write frame SHALL use csb=0; read/commit frame SHALL use csb=1 with data=0.
REQ-020 FSM states SHALL be IDLE, SHIFT_W, HOLD_W, SHIFT_R, HOLD_R, FIN.
REQ-021 wr_ready SHALL be 1 only in IDLE; a handshake occurs on wr_valid&wr_ready and latches wr_addr and wr_data.
REQ-022 On handshake with wr_addr<NUM_WORDS: IDLE->SHIFT_W. With wr_addr>=NUM_WORDS: set err, stay IDLE, emit no frame, no done.
REQ-023 In SHIFT_W/SHIFT_R, cfg_scan_en SHALL be 1 for exactly FRAME_W consecutive cycles; cfg_scan_in SHALL present frame bit 38 first, bit 0 last.
REQ-024 In HOLD_W/HOLD_R, cfg_scan_en=0 and cfg_scan_in=0 for exactly HOLD_CYC cycles; then HOLD_W->SHIFT_R and HOLD_R->FIN.
REQ-025 FIN SHALL last 1 cycle: done=1, words_loaded increments (saturating at 31), then ->IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 Per-word latency from handshake to done SHALL be 2*(FRAME_W+HOLD_CYC)+1 cycles (83 at defaults); back-to-back words SHALL be separated by 1 IDLE cycle.
REQ-028 err_clr SHALL be honoured in any state; if it coincides with FIN, the count SHALL become 0; if it coincides with a bad-address handshake, err SHALL end at 1.
REQ-029 wr_data/wr_addr changes after handshake SHALL NOT affect the in-flight frame.

Reset
REQ-030 While cfg_rst=1: state=IDLE, bit counter=0, hold counter=0, cfg_scan_en=0, cfg_scan_in=0, done=0, err=0, words_loaded=0, busy=0; wr_ready=1 after release.
REQ-031 Reset asserted mid-shift SHALL abort the frame immediately with no done; the host SHALL resend the word.

Structure
REQ-032 A shared package SHALL hold the frame bit-position constants, state enum, and default NUM_WORDS/FRAME_W.
REQ-033 The FRAME_W-bit parallel-load shift register SHALL be a sub-module cfg_frame_shifter (load, shift, msb-out).
REQ-034 Implementation SHALL be synthesizable, with a single always-block per register group, and no latches.

Verification
REQ-035 Send addr=1, data=0xDEADBEEF -> 39 scan_en cycles with serial bits equal to {0xDEADBEEF,0,1,0,0001}, 2 idle cycles, 39 cycles of {0,1,1,0,0001}, done at cycle 83, words_loaded=1.
REQ-036 Send addr=13 -> err=1, no scan_en activity, words_loaded unchanged; err_clr -> err=0.
REQ-037 Stream 13 words, addr 0..12, with wr_valid held high -> 13 done pulses spaced 84 cycles apart, words_loaded=13; a tile-model bench reads back all 13 sram_output_cfg words matching the sent data.
REQ-038 Assert cfg_rst at bit 20 of SHIFT_W -> outputs zero immediately, no done, and the next word loads normally.
REQ-039 Assert err_clr in the FIN cycle -> words_loaded=0 next cycle and done still pulses.
REQ-040 Change wr_data during SHIFT_W -> the serialized frame is unchanged.
